// File: rtl/dtree_node_walker.sv
// dtree_node_walker: node-serial decision-tree engine. One shared comparator
// walks a host-programmed node table, one node per cycle, between a
// valid/ready feature source and a valid/ready class consumer.
// Optional build macro: DTREE_PERF_EN enables the saturating perf_samples /
// perf_cycles counters; without it both outputs are tied to zero.
module dtree_node_walker #(
   parameter int unsigned FEAT_W    = 8,
   parameter int unsigned CLASS_W   = 4,
   parameter int unsigned N_NODES   = 16,
   parameter int unsigned MAX_STEPS = 15,
   localparam int unsigned IDX_W    = $clog2(N_NODES),
   localparam int unsigned ENTRY_W  = 1 + 3 + FEAT_W + 2 * IDX_W + CLASS_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FEAT_W-1:0]  in_feat,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLASS_W-1:0] out_class,
   output logic               out_err,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_addr,
   input  logic [ENTRY_W-1:0] cfg_wdata,
   output logic               cfg_busy,
   output logic [15:0]        perf_samples,
   output logic [15:0]        perf_cycles
);

   localparam int unsigned STEP_W  = $clog2(MAX_STEPS + 1);
   // entry field offsets, LSB first: class, f_idx, t_idx, thr, shift, leaf
   localparam int unsigned F_LSB   = CLASS_W;
   localparam int unsigned T_LSB   = CLASS_W + IDX_W;
   localparam int unsigned THR_LSB = CLASS_W + 2 * IDX_W;
   localparam int unsigned SH_LSB  = THR_LSB + FEAT_W;
   localparam int unsigned LEAF_B  = ENTRY_W - 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WALK = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [ENTRY_W-1:0] LEAF_RESET = ENTRY_W'(1) << LEAF_B;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [ENTRY_W-1:0] node_tbl [N_NODES];
   logic [FEAT_W-1:0]  feat;
   logic [IDX_W-1:0]   node;
   logic [STEP_W-1:0]  step;

   logic [ENTRY_W-1:0] cur;
   logic [FEAT_W-1:0]  shifted;
   logic [IDX_W-1:0]   nxt_idx;
   logic               walk_end;
   logic [CLASS_W-1:0] res_class;
   logic               res_err;

   // Node evaluation and next-state decode
   always_comb begin
      state_nxt = state;
      cur       = '0;
      shifted   = '0;
      nxt_idx   = '0;
      walk_end  = 1'b0;
      res_class = '1;
      res_err   = 1'b1;

      if (32'(node) < N_NODES) begin
         cur     = node_tbl[node];
         shifted = feat >> cur[SH_LSB +: 3];
         nxt_idx = (shifted <= cur[THR_LSB +: FEAT_W]) ? cur[T_LSB +: IDX_W]
                                                        : cur[F_LSB +: IDX_W];
         if (cur[LEAF_B]) begin
            walk_end  = 1'b1;
            res_class = cur[CLASS_W-1:0];
            res_err   = 1'b0;
         end else if (step == STEP_W'(MAX_STEPS - 1)) begin
            walk_end = 1'b1;
         end
      end else begin
         walk_end = 1'b1;
      end

      case (state)
         IDLE:    if (in_valid)  state_nxt = WALK;
         WALK:    if (walk_end)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register with registered handshake/status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cfg_busy  <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         cfg_busy  <= (state_nxt != IDLE);
      end
   end

   // Node table, walk pointer and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         feat      <= '0;
         node      <= '0;
         step      <= '0;
         out_class <= '0;
         out_err   <= 1'b0;
         for (int i = 0; i < int'(N_NODES); i++) node_tbl[i] <= LEAF_RESET;
      end else begin
         if (state == IDLE && cfg_we && 32'(cfg_addr) < N_NODES)
            node_tbl[cfg_addr] <= cfg_wdata;
         if (state == IDLE && in_valid) begin
            feat <= in_feat;
            node <= '0;
            step <= '0;
         end
         if (state == WALK) begin
            if (walk_end) begin
               out_class <= res_class;
               out_err   <= res_err;
            end else begin
               node <= nxt_idx;
               step <= step + STEP_W'(1);
            end
         end
      end
   end

`ifdef DTREE_PERF_EN
   // Saturating sample and walk-cycle counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_samples <= '0;
         perf_cycles  <= '0;
      end else begin
         if (state == DONE && out_ready && perf_samples != 16'hFFFF)
            perf_samples <= perf_samples + 16'd1;
         if (state == WALK && perf_cycles != 16'hFFFF)
            perf_cycles <= perf_cycles + 16'd1;
      end
   end
`else
   assign perf_samples = '0;
   assign perf_cycles  = '0;
`endif

endmodule

// File: tb/tb_dtree_node_walker.sv
// Self-checking bench for dtree_node_walker: directed vector table, multi-cycle
// corner sequences and randomized tables checked against a loop-based model.
module tb_dtree_node_walker;

   localparam int N_NODES   = 16;
   localparam int MAX_STEPS = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_feat;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_class;
   logic        out_err;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [23:0] cfg_wdata;
   logic        cfg_busy;
   logic [15:0] perf_samples;
   logic [15:0] perf_cycles;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [23:0] mtbl [N_NODES];

   typedef struct {
      logic [7:0] feat;
      logic [3:0] cls;
      logic       err;
      int         lat;   // cycles from accept cycle T to first out_valid
      int         hold;
   } vec_t;
   vec_t vecs [6];

   dtree_node_walker dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_err(out_err),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_busy(cfg_busy),
      .perf_samples(perf_samples), .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [23:0] mk(input logic leaf, input logic [2:0] s,
                                      input logic [7:0] thr, input logic [3:0] t,
                                      input logic [3:0] f, input logic [3:0] cls);
      return {leaf, s, thr, t, f, cls};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: follow the tree from the root, counting visited nodes.
   function automatic void model(input logic [7:0] x, output logic [3:0] cls,
                                 output logic err, output int walk);
      int n = 0;
      logic [23:0] e;
      walk = 0;
      cls  = 4'hF;
      err  = 1'b1;
      for (int k = 0; k < MAX_STEPS; k++) begin
         walk++;
         if (n >= N_NODES) return;
         e = mtbl[n];
         if (e[23]) begin
            cls = e[3:0];
            err = 1'b0;
            return;
         end
         n = (int'(x >> e[22:20]) <= int'(e[19:12])) ? int'(e[11:8]) : int'(e[7:4]);
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_NODES; i++) mtbl[i] = mk(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
   endtask

   task automatic cfg_write(input logic [3:0] addr, input logic [23:0] data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      mtbl[addr] = data;
   endtask

   // Present a sample once in_ready is seen; returns the accept-edge count.
   task automatic start_sample(input logic [7:0] x, output int a);
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = in_ready;
      end
      if (!seen) check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b1; in_feat = x;
      @(posedge clk); #1;
      a = cyc;
      in_valid = 1'b0;
   endtask

   // Wait for the result, check value/latency, stall `hold` cycles, then handshake.
   task automatic finish_sample(input string name, input logic [3:0] ecls, input logic eerr,
                                input int lat, input int a, input int hold);
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) begin
         check({name, "_valid_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({name, "_latency"}, 32'(cyc - a + 1), 32'(lat));
      check({name, "_class"}, 32'(out_class), 32'(ecls));
      check({name, "_err"}, 32'(out_err), 32'(eerr));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, "_hold_class"}, {out_valid, in_ready, out_class}, {1'b1, 1'b0, ecls});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({name, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   task automatic run_model(input string name, input logic [7:0] x, input int hold);
      int a, w;
      logic [3:0] c;
      logic e;
      model(x, c, e, w);
      start_sample(x, a);
      finish_sample(name, c, e, w + 1, a, hold);
   endtask

   initial begin
      int a;
      bit seen;
      rst = 1'b1; in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      model_reset();

      vecs[0] = '{8'h40, 4'd3, 1'b0, 3, 0};
      vecs[1] = '{8'hC0, 4'd7, 1'b0, 3, 2};
      vecs[2] = '{8'h00, 4'd3, 1'b0, 3, 0};
      vecs[3] = '{8'h7F, 4'd3, 1'b0, 3, 1};
      vecs[4] = '{8'h80, 4'd7, 1'b0, 3, 0};
      vecs[5] = '{8'hFF, 4'd7, 1'b0, 3, 3};

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_class", 32'(out_class), 32'd0);
      check("reset_out_err", 32'(out_err), 32'd0);
      check("reset_cfg_busy", 32'(cfg_busy), 32'd0);
      check("reset_perf", {perf_samples, perf_cycles}, 32'd0);

      run_model("reset_table", 8'h5A, 0);

      // root leaf class 5
      cfg_write(4'd0, mk(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd5));
      start_sample(8'h00, a);
      finish_sample("root_leaf", 4'd5, 1'b0, 2, a, 0);

      // two-level tree from the vector table
      cfg_write(4'd0, mk(1'b0, 3'd6, 8'd1, 4'd1, 4'd2, 4'd0));
      cfg_write(4'd1, mk(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd3));
      cfg_write(4'd2, mk(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd7));
      for (int i = 0; i < 6; i++) begin
         start_sample(vecs[i].feat, a);
         finish_sample($sformatf("vec%0d", i), vecs[i].cls, vecs[i].err, vecs[i].lat, a, vecs[i].hold);
      end

      // long consumer stall
      start_sample(8'h40, a);
      finish_sample("stall10", 4'd3, 1'b0, 3, a, 10);

      // self-loop root times out; a write during WALK is dropped
      cfg_write(4'd0, mk(1'b0, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0));
      start_sample(8'h33, a);
      @(negedge clk);
      check("walk_cfg_busy", {in_ready, cfg_busy}, 32'b01);
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = mk(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd2);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      finish_sample("timeout", 4'hF, 1'b1, MAX_STEPS + 1, a, 0);
      start_sample(8'h01, a);
      finish_sample("dropped_write", 4'hF, 1'b1, MAX_STEPS + 1, a, 1);

      // write and accept in the same IDLE cycle: walk sees the new root
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = mk(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd11);
      in_valid = 1'b1; in_feat = 8'h99;
      @(posedge clk); #1;
      a = cyc;
      cfg_we = 1'b0; in_valid = 1'b0;
      mtbl[0] = mk(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd11);
      finish_sample("same_cycle_write", 4'd11, 1'b0, 2, a, 0);

      // randomized tables against the model
      for (int r = 0; r < 5; r++) begin
         for (int n = 0; n < N_NODES; n++)
            cfg_write(4'(n), mk(($urandom_range(0, 9) < 4), 3'($urandom), 8'($urandom),
                                4'($urandom), 4'($urandom), 4'($urandom)));
         for (int k = 0; k < 10; k++)
            run_model($sformatf("rand%0d_%0d", r, k), 8'($urandom), $urandom_range(0, 3));
      end

      // reset mid-WALK aborts without a clock edge
      cfg_write(4'd0, mk(1'b0, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0));
      start_sample(8'h10, a);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_walk", {29'd0, out_valid, in_ready, cfg_busy}, 32'b010);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;

      // reset while holding a result in DONE
      start_sample(8'h22, a);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check("done_reached", 32'(seen), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_done", {30'd0, out_valid, in_ready}, 32'b01);
      @(posedge clk); #1 rst = 1'b0;

      // three samples on the reset table
      for (int k = 0; k < 3; k++) run_model($sformatf("post_rst%0d", k), 8'($urandom), 0);
      @(negedge clk);
`ifdef DTREE_PERF_EN
      check("perf_samples", 32'(perf_samples), 32'd3);
      check("perf_cycles", 32'(perf_cycles), 32'd3);
`else
      check("perf_tied_off", {perf_samples, perf_cycles}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

endmodule
